// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                          |
// | Brief    : Shared constants and beat type for the ALU result stage.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int RD_W  = 4;

    localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

    // Bit positions inside the {Z,V,N} flag-write-enable vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             wen;
    } alu_beat_t;

endpackage
`default_nettype wire

// File: rtl/alu_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_skid_fifo                                                    |
// | Brief    : 2-entry FIFO of alu_beat_t with push/pop/flush; head at r_head.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_skid_fifo
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  logic      i_push,
    input  logic      i_pop,
    input  alu_beat_t i_beat,
    output alu_beat_t o_head,
    output logic [1:0] o_count,
    output logic      o_full,
    output logic      o_empty
);

    alu_beat_t  r_head;
    alu_beat_t  r_tail;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Entries shift toward r_head so the output never needs a read mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (o_empty) r_head <= i_beat;
                    else         r_tail <= i_beat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head <= i_beat;
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_result_stage                                                 |
// | Brief    : Saturation, Z/V/N flags and skid queue after the 16-bit CLA.     |
// |            Saturation enabled by defining ALU_SAT_EN (default: wrap).       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int RD_W  = alu_pkg::RD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_ovfl,
    input  logic [2:0]       in_flag_we,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_wen,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_wen,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_count;
    logic [WIDTH-1:0] w_result;
    alu_beat_t        w_beat;
    alu_beat_t        w_head;
    logic             r_flag_z;
    logic             r_flag_v;
    logic             r_flag_n;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_comb begin
        w_result = in_sum;
`ifdef ALU_SAT_EN
        // A set sign bit on overflow means the true result was positive
        if (in_ovfl) w_result = in_sum[WIDTH-1] ? SAT_MAX : SAT_MIN;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_accept) begin
            if (in_flag_we[FLAG_Z]) r_flag_z <= (w_result == '0);
            if (in_flag_we[FLAG_V]) r_flag_v <= in_ovfl;
            if (in_flag_we[FLAG_N]) r_flag_n <= w_result[WIDTH-1];
        end
    end

    assign w_beat = '{result: w_result, rd: in_rd, wen: in_wen};

    alu_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_beat  (w_beat),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assert property (@(posedge clk) disable iff (rst) w_count != 2'd3);

    assign out_result = w_head.result;
    assign out_rd     = w_head.rd;
    assign out_wen    = w_head.wen;
    assign flag_z     = r_flag_z;
    assign flag_v     = r_flag_v;
    assign flag_n     = r_flag_n;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_result_stage                                              |
// | Brief    : Directed self-checking bench; expectations follow ALU_SAT_EN.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_ovfl;
    logic [2:0]  in_flag_we;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic [2:0]  flags;

    int checks   = 0;
    int failures = 0;

    assign flags = {flag_z, flag_v, flag_n};

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_ovfl    (in_ovfl),
        .in_flag_we (in_flag_we),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic o,
                         input logic [2:0] we, input logic [3:0] rd, input logic wen);
        in_valid   = v;
        in_sum     = s;
        in_ovfl    = o;
        in_flag_we = we;
        in_rd      = rd;
        in_wen     = wen;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL reset_out_result got=%h exp=0000", out_result); end
        checks++; if ({out_rd, out_wen} !== 5'b0) begin failures++; $display("FAIL reset_rd_wen got=%h/%b exp=0/0", out_rd, out_wen); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp1, exp2;
        logic [2:0]  expf1, expf2;
`ifdef ALU_SAT_EN
        exp1 = 16'h7FFF; expf1 = 3'b010;
        exp2 = 16'h8000; expf2 = 3'b011;
`else
        exp1 = 16'h8001; expf1 = 3'b011;
        exp2 = 16'h7FFF; expf2 = 3'b010;
`endif
        out_ready = 1'b1;
        drive(1'b1, 16'h8001, 1'b1, 3'b111, 4'd5, 1'b1);
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat1_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== exp1) begin failures++; $display("FAIL sat1_result got=%h exp=%h", out_result, exp1); end
        checks++; if ({out_rd, out_wen} !== {4'd5, 1'b1}) begin failures++; $display("FAIL sat1_rd_wen got=%0d/%b exp=5/1", out_rd, out_wen); end
        checks++; if (flags !== expf1) begin failures++; $display("FAIL sat1_flags got=%b exp=%b", flags, expf1); end
        drive(1'b1, 16'h7FFF, 1'b1, 3'b111, 4'd6, 1'b0);
        step();
        checks++; if (out_result !== exp2) begin failures++; $display("FAIL sat2_result got=%h exp=%h", out_result, exp2); end
        checks++; if ({out_rd, out_wen} !== {4'd6, 1'b0}) begin failures++; $display("FAIL sat2_rd_wen got=%0d/%b exp=6/0", out_rd, out_wen); end
        checks++; if (flags !== expf2) begin failures++; $display("FAIL sat2_flags got=%b exp=%b", flags, expf2); end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_flag_mask();
        logic [15:0] prep;
`ifdef ALU_SAT_EN
        prep = 16'h7FFF;
`else
        prep = 16'h8001;
`endif
        out_ready = 1'b1;
        drive(1'b1, prep, 1'b1, 3'b111, 4'd1, 1'b1);
        step();
        checks++; if (flags !== 3'b011) begin failures++; $display("FAIL mask_prep_flags got=%b exp=011", flags); end
        drive(1'b1, 16'h0000, 1'b0, 3'b100, 4'd2, 1'b1);
        step();
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL mask_result got=%h exp=0000", out_result); end
        checks++; if (flags !== 3'b111) begin failures++; $display("FAIL mask_flags got=%b exp=111", flags); end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, 1'b0, 3'b000, 4'd1, 1'b1);
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        checks++; if (out_result !== 16'h0011) begin failures++; $display("FAIL bp_head1 got=%h exp=0011", out_result); end
        drive(1'b1, 16'h0022, 1'b0, 3'b000, 4'd2, 1'b1);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        drive(1'b1, 16'h0033, 1'b0, 3'b000, 4'd3, 1'b0);
        step();
        checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL bp_stall_hs got=%b%b exp=10", out_valid, in_ready); end
        checks++; if ({out_result, out_rd} !== {16'h0011, 4'd1}) begin failures++; $display("FAIL bp_held got=%h/%0d exp=0011/1", out_result, out_rd); end
        out_ready = 1'b1;
        step();
        checks++; if ({out_result, out_rd} !== {16'h0022, 4'd2}) begin failures++; $display("FAIL bp_second got=%h/%0d exp=0022/2", out_result, out_rd); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
        step();
        checks++; if ({out_valid, out_result, out_rd, out_wen} !== {1'b1, 16'h0033, 4'd3, 1'b0}) begin failures++; $display("FAIL bp_third got=%b/%h/%0d/%b exp=1/0033/3/0", out_valid, out_result, out_rd, out_wen); end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        checks++; if (flags !== 3'b111) begin failures++; $display("FAIL bp_flags got=%b exp=111", flags); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 16'h0044, 1'b0, 3'b000, 4'd4, 1'b1);
        step();
        out_ready = 1'b1;
        drive(1'b1, 16'h0055, 1'b0, 3'b000, 4'd5, 1'b1);
        step();
        checks++; if ({out_valid, in_ready} !== 2'b11) begin failures++; $display("FAIL b2b_count1 got=%b%b exp=11", out_valid, in_ready); end
        checks++; if ({out_result, out_rd} !== {16'h0055, 4'd5}) begin failures++; $display("FAIL b2b_order got=%h/%0d exp=0055/5", out_result, out_rd); end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 16'h0101, 1'b0, 3'b111, 4'd7, 1'b1);
        step();
        drive(1'b1, 16'h0202, 1'b0, 3'b000, 4'd8, 1'b1);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
        drive(1'b1, 16'h0000, 1'b1, 3'b111, 4'd9, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_full_hs got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL flush_full_flags got=%b exp=000", flags); end
        drive(1'b1, 16'h0303, 1'b0, 3'b000, 4'd10, 1'b1);
        step();
        drive(1'b1, 16'h0000, 1'b1, 3'b111, 4'd9, 1'b1);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_valid got=%b exp=0", out_valid); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL flush_input_flags got=%b exp=000", flags); end
        drive(1'b1, 16'h0005, 1'b0, 3'b111, 4'd11, 1'b0);
        step();
        checks++; if ({out_valid, out_result, out_rd} !== {1'b1, 16'h0005, 4'd11}) begin failures++; $display("FAIL flush_after got=%b/%h/%0d exp=1/0005/11", out_valid, out_result, out_rd); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL flush_after_flags got=%b exp=000", flags); end
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 16'h8000, 1'b0, 3'b111, 4'd12, 1'b1);
        step();
        drive(1'b1, 16'h1234, 1'b0, 3'b000, 4'd13, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        checks++; if ({in_ready, flags} !== 4'b0001) begin failures++; $display("FAIL rstm_pre got=%b/%b exp=0/001", in_ready, flags); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rstm_hs got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL rstm_flags got=%b exp=000", flags); end
        checks++; if ({out_result, out_rd, out_wen} !== 21'b0) begin failures++; $display("FAIL rstm_head got=%h/%0d/%b exp=0/0/0", out_result, out_rd, out_wen); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstm_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 3'b000, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_saturation();
        test_flag_mask();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
